fifo_sync_param: RTL

Parametrised synchronous FIFO succeeding the fixed 256x256 pixel FIFO in the median-filter datapath. Decouples pixel producers (image reader, line buffers) from the median window consumer. Replaces the single `en`/`push_pop` mode control with independent push and pop that may occur in the same cycle. Adds an occupancy count, programmable almost-full/almost-empty thresholds and optional sticky error flags.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 36 +++
 rtl/fifo_sync_param.sv | 115 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the parametrised synchronous pixel FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 65536;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x DATA_WIDTH memory: synchronous write, registered read-first port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [0:(1 << ADDR_WIDTH)-1];

  // Storage array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register: old contents win when reading and writing one address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count and threshold flags.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        valid_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [ptr_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_next_s;
  logic [PW-1:0] rd_ptr_next_s;
  logic [PW-1:0] count_next_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Acceptance from pre-edge flags; occupancy is the pointer distance, which
  // moves exactly as push-only increments and pop-only decrements.
  always_comb begin
    push_ok_s     = push & (~full | pop);
    pop_ok_s      = pop & ~empty;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    if (push_ok_s) begin
      wr_ptr_next_s = wr_ptr_r + PW'(1'b1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_ok_s) begin
      rd_ptr_next_s = rd_ptr_r + PW'(1'b1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    count_next_s = wr_ptr_next_s - rd_ptr_next_s;
  end

  // Pointers, count and status flags, all registered from next-state occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count        <= {PW{1'b0}};
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      valid_out    <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_ptr_next_s;
      rd_ptr_r     <= rd_ptr_next_s;
      count        <= count_next_s;
      full         <= (count_next_s == PW'(DEPTH));
      empty        <= (count_next_s == {PW{1'b0}});
      almost_full  <= (count_next_s >= PW'(AF_LEVEL));
      almost_empty <= (count_next_s <= PW'(AE_LEVEL));
      valid_out    <= pop_ok_s;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok_s),
    .wr_addr (wr_ptr_r[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (pop_ok_s),
    .rd_addr (rd_ptr_r[AW-1:0]),
    .rd_data (data_out)
  );

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & ~push_ok_s) begin
        overflow <= 1'b1;
      end
      if (pop & ~pop_ok_s) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
